// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: word width and FSM state encodings.
package memory_port_arbiter_pkg;
    localparam int WORD_SIZE = 16;

    typedef logic [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;
endpackage

// File: rtl/memory_port_arbiter_if.sv
// Bundle of pipeline-side (IF/MEM) and memory-side signals around the arbiter.
interface memory_port_arbiter_if;
    import memory_port_arbiter_pkg::*;

    logic  i_req, i_abort, i_ready, i_stall;
    word_t i_addr, i_data;
    logic  d_read, d_write, d_ready, d_stall;
    word_t d_addr, d_wdata, d_rdata;
    logic  mem_read, mem_write;
    word_t mem_addr, mem_wdata, mem_rdata;

    modport slave (
        input  i_req, i_addr, i_abort, d_read, d_write, d_addr, d_wdata, mem_rdata,
        output i_ready, i_data, i_stall, d_ready, d_rdata, d_stall,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, i_abort, d_read, d_write, d_addr, d_wdata, mem_rdata,
        input  i_ready, i_data, i_stall, d_ready, d_rdata, d_stall,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/memory_port_arbiter_mem_latency_counter.sv
// Busy-cycle counter: loads MEM_LATENCY-1 on grant, counts down, saturates at zero.
module mem_latency_counter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(MEM_LATENCY - 1);
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/memory_port_arbiter.sv
// Single-port memory arbiter between IF and MEM stages: D-over-I priority,
// fixed-latency access sequencing, registered ready pulses and stall generation.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    memory_port_arbiter_if.slave bus
);
    arb_state_e state;
    logic  aborted;
    logic  i_ready_q, d_ready_q, mem_read_q, mem_write_q;
    word_t i_data_q, d_rdata_q, mem_addr_q, mem_wdata_q;
    logic  cnt_load, cnt_dec, cnt_zero;
    logic  d_req, i_go;

    assign d_req    = bus.d_read || bus.d_write;
    assign i_go     = bus.i_req && !bus.i_abort;
    assign cnt_load = (state == ARB_IDLE) && (d_req || i_go);
    assign cnt_dec  = (state == ARB_I_BUSY) || (state == ARB_D_BUSY);

    mem_latency_counter #(.MEM_LATENCY(MEM_LATENCY)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            aborted     <= 1'b0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_data_q    <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (d_req) begin
                        // Store wins an (illegal) simultaneous read+write.
                        state       <= ARB_D_BUSY;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                        mem_write_q <= bus.d_write;
                        mem_read_q  <= !bus.d_write;
                    end else if (i_go) begin
                        state      <= ARB_I_BUSY;
                        mem_addr_q <= bus.i_addr;
                        mem_read_q <= 1'b1;
                        aborted    <= 1'b0;
                    end
                end
                ARB_I_BUSY: begin
                    if (bus.i_abort)
                        aborted <= 1'b1;
                    if (cnt_zero) begin
                        state      <= ARB_DONE;
                        mem_read_q <= 1'b0;
                        i_data_q   <= bus.mem_rdata;
                        i_ready_q  <= !(aborted || bus.i_abort);
                    end
                end
                ARB_D_BUSY: begin
                    if (cnt_zero) begin
                        state       <= ARB_DONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        d_ready_q   <= 1'b1;
                        if (!mem_write_q)
                            d_rdata_q <= bus.mem_rdata;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.i_data    = i_data_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Stalls are forced low during reset so every output reads zero.
    assign bus.i_stall = !reset && bus.i_req && !i_ready_q;
    assign bus.d_stall = !reset && d_req && !d_ready_q;

    assert property (@(posedge clk) disable iff (reset) !(bus.d_read && bus.d_write));
    assert property (@(posedge clk) disable iff (reset) !(mem_read_q && mem_write_q));
endmodule
